// File: rtl/vending_pkg.sv
// Shared vending definitions: the 1-bit coin encoding, coin unit values and
// the change-dispenser state enum, common to the acceptor and the dispenser.
package vending_pkg;

  localparam logic COIN_DIME   = 1'b0;
  localparam logic COIN_NICKEL = 1'b1;

  localparam int DIME_UNITS   = 2;
  localparam int NICKEL_UNITS = 1;

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    DONE
  } disp_state_e;

  // Value of one coin in nickel units.
  function automatic int coin_value(input logic coin);
    return (coin == COIN_NICKEL) ? NICKEL_UNITS : DIME_UNITS;
  endfunction

endpackage

// File: rtl/coin_dispenser.sv
// Change-return transmitter: turns a change amount (nickel units) into a
// stream of dime/nickel coins, one per valid/ready handshake with the hopper.
module coin_dispenser
  import vending_pkg::*;
#(
  parameter int AMOUNT_W = 4,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_req_valid,
  input  logic [AMOUNT_W-1:0] io_req_amount,
  output logic                io_req_ready,
  input  logic                io_dime_empty,
  output logic                io_coin_valid,
  output logic                io_coin,
  input  logic                io_coin_ready,
  output logic                io_done,
  output logic [CNT_W-1:0]    io_count
);

  disp_state_e         state_reg, state_next;
  logic [AMOUNT_W-1:0] remaining_reg, remaining_next;
  logic                coin_reg, coin_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [AMOUNT_W-1:0] after_coin;

  // A dime is only offered when at least two units remain, so the remainder
  // can never underflow and an odd amount always finishes on a nickel.
  function automatic logic select_coin(input logic [AMOUNT_W-1:0] rem,
                                       input logic dime_empty);
    if (rem >= AMOUNT_W'(DIME_UNITS) && !dime_empty)
      return COIN_DIME;
    return COIN_NICKEL;
  endfunction

  assign after_coin = remaining_reg - AMOUNT_W'(coin_value(coin_reg));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      coin_reg      <= COIN_NICKEL;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      coin_reg      <= coin_next;
      count_reg     <= count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    coin_next      = coin_reg;
    count_next     = count_reg;
    case (state_reg)
      IDLE: begin
        if (io_req_valid) begin
          remaining_next = io_req_amount;
          count_next     = '0;
          if (io_req_amount == '0) begin
            state_next = DONE;
          end else begin
            state_next = DISPENSE;
            coin_next  = select_coin(io_req_amount, io_dime_empty);
          end
        end
      end
      DISPENSE: begin
        // coin_reg only changes on a handshake, so a stalled offer stays put.
        if (io_coin_ready) begin
          remaining_next = after_coin;
          count_next     = (count_reg == '1) ? count_reg : count_reg + CNT_W'(1);
          if (after_coin == '0)
            state_next = DONE;
          else
            coin_next = select_coin(after_coin, io_dime_empty);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    io_req_ready  = (state_reg == IDLE);
    io_coin_valid = (state_reg == DISPENSE);
    io_done       = (state_reg == DONE);
    io_coin       = coin_reg;
    io_count      = count_reg;
  end

endmodule

// File: tb/tb_coin_dispenser.sv
// Bench for coin_dispenser: directed transactions, a per-cycle reference model
// and literal expectations for coin sequences, counts and done latency.
module tb_coin_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       io_req_valid = 1'b0;
  logic [3:0] io_req_amount = '0;
  logic       io_req_ready;
  logic       io_dime_empty = 1'b0;
  logic       io_coin_valid;
  logic       io_coin;
  logic       io_coin_ready = 1'b0;
  logic       io_done;
  logic [3:0] io_count;

  int checks = 0;
  int failures = 0;

  coin_dispenser #(.AMOUNT_W(4), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_req_valid (io_req_valid),
    .io_req_amount(io_req_amount),
    .io_req_ready (io_req_ready),
    .io_dime_empty(io_dime_empty),
    .io_coin_valid(io_coin_valid),
    .io_coin      (io_coin),
    .io_coin_ready(io_coin_ready),
    .io_done      (io_done),
    .io_count     (io_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: phase 0 = waiting for a request, 1 = offering coins,
  // 2 = reporting completion. Coin choice follows the dime/nickel rule directly.
  int   m_phase = 0;
  int   m_rem = 0;
  int   m_count = 0;
  logic m_coin = 1'b1;

  function automatic logic pick(input int rem, input logic dime_empty);
    return (rem >= 2 && !dime_empty) ? 1'b0 : 1'b1;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    int   r;
    int   c;
    int   p;
    logic k;
    if (!reset) begin
      m_phase <= 0;
      m_rem   <= 0;
      m_coin  <= 1'b1;
      m_count <= 0;
    end else begin
      r = m_rem; c = m_count; p = m_phase; k = m_coin;
      if (m_phase == 0) begin
        if (io_req_valid) begin
          r = int'(io_req_amount);
          c = 0;
          if (r == 0) p = 2;
          else begin p = 1; k = pick(r, io_dime_empty); end
        end
      end else if (m_phase == 1) begin
        if (io_coin_ready) begin
          r = r - (m_coin ? 1 : 2);
          c = (c >= 15) ? 15 : c + 1;
          if (r == 0) p = 2;
          else k = pick(r, io_dime_empty);
        end
      end else begin
        p = 0;
      end
      m_rem <= r; m_count <= c; m_phase <= p; m_coin <= k;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("cyc_req_ready", io_req_ready, m_phase == 0);
      check("cyc_coin_valid", io_coin_valid, m_phase == 1);
      check("cyc_done", io_done, m_phase == 2);
      check("cyc_count", io_count, m_count);
      if (m_phase == 1) check("cyc_coin", io_coin, m_coin);
    end
  end

  // Coins actually handed over, and completion pulses seen.
  logic coin_log[$];
  int   done_pulses = 0;
  int   valid_cycles = 0;

  always @(posedge clk) begin
    if (reset && io_coin_valid && io_coin_ready) coin_log.push_back(io_coin);
    if (reset && io_done) done_pulses++;
    if (reset && io_coin_valid) valid_cycles++;
  end

  function automatic int log_pattern();
    int v = 0;
    foreach (coin_log[i]) v = v * 2 + int'(coin_log[i]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int bound, output int cycles);
    cycles = 0;
    while (io_done !== 1'b1 && cycles < bound) begin
      tick();
      cycles++;
    end
    if (io_done !== 1'b1) check({name, "_done_timeout"}, io_done, 1);
  endtask

  task automatic accept(input int amount);
    coin_log.delete();
    io_req_valid  = 1'b1;
    io_req_amount = 4'(amount);
    tick();
    io_req_valid = 1'b0;
  endtask

  task automatic finish_txn(input string name, input int amount, input int cycles,
                            input int exp_cycles, input int exp_n, input int exp_pat);
    $display("txn %s amount=%0d coins=%0d pattern=%0d count=%0d done_after=%0d",
             name, amount, coin_log.size(), log_pattern(), io_count, cycles);
    check({name, "_latency"}, cycles, exp_cycles);
    check({name, "_ncoins"}, coin_log.size(), exp_n);
    check({name, "_pattern"}, log_pattern(), exp_pat);
    check({name, "_count"}, io_count, exp_n);
    tick();
    check({name, "_back_idle"}, io_req_ready, 1);
  endtask

  initial begin
    int cyc;
    int dp;
    #11;
    check("rst_req_ready", io_req_ready, 1);
    check("rst_coin_valid", io_coin_valid, 0);
    check("rst_coin", io_coin, 1);
    check("rst_done", io_done, 0);
    check("rst_count", io_count, 0);
    reset = 1'b1;
    tick();

    // 5 units with dimes: dime, dime, nickel back to back.
    io_coin_ready = 1'b1; io_dime_empty = 1'b0;
    accept(5);
    wait_done("amt5", 20, cyc);
    finish_txn("amt5", 5, cyc, 3, 3, 1);

    // 4 units, dime tube empty: four nickels.
    io_dime_empty = 1'b1;
    accept(4);
    wait_done("amt4_empty", 20, cyc);
    finish_txn("amt4_empty", 4, cyc, 4, 4, 15);

    // 6 units, first dime stalled three cycles while the tube runs dry.
    io_dime_empty = 1'b0; io_coin_ready = 1'b0;
    accept(6);
    check("stall0_coin", io_coin, 0);
    tick();
    check("stall1_coin", io_coin, 0);
    io_dime_empty = 1'b1;
    tick();
    check("stall2_coin", io_coin, 0);
    tick();
    check("stall3_coin", io_coin, 0);
    check("stall3_valid", io_coin_valid, 1);
    io_coin_ready = 1'b1;
    wait_done("amt6_stall", 20, cyc);
    finish_txn("amt6_stall", 6, cyc, 5, 5, 15);

    // Zero amount: done on the cycle after acceptance, no coin offered.
    io_dime_empty = 1'b0;
    valid_cycles = 0;
    io_req_valid = 1'b1; io_req_amount = 4'd0;
    check("zero_ready_at_accept", io_req_ready, 1);
    accept(0);
    check("zero_done_next", io_done, 1);
    check("zero_no_valid", valid_cycles, 0);
    finish_txn("amt0", 0, 0, 0, 0, 0);

    // A second request during dispensing is ignored.
    accept(4);
    io_req_valid = 1'b1; io_req_amount = 4'd3;
    tick();
    check("busy_ready", io_req_ready, 0);
    wait_done("amt4_busy", 20, cyc);
    io_req_valid = 1'b0;
    finish_txn("amt4_busy", 4, cyc + 1, 2, 2, 0);
    check("busy_not_taken", io_coin_valid, 0);

    // Reset mid-transaction aborts without a done pulse.
    accept(7);
    tick();
    #2;
    dp = done_pulses;
    reset = 1'b0;
    #1;
    check("abort_valid", io_coin_valid, 0);
    check("abort_ready", io_req_ready, 1);
    check("abort_coin", io_coin, 1);
    check("abort_count", io_count, 0);
    repeat (3) tick();
    check("abort_no_done", done_pulses, dp);
    reset = 1'b1;
    tick();
    accept(1);
    check("after_rst_coin", io_coin, 1);
    wait_done("amt1", 20, cyc);
    finish_txn("amt1", 1, cyc, 1, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
